sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-port arbiter sharing the single data SRAM between the core load/store path (address generator side) and an external host/DMA port. It sits between the address generator outputs and `sram`. It serialises accesses with a req/gnt handshake and tracks read returns. A host burst lock is bounded so the core is never starved indefinitely. The core stalls (holds PC) while `c_stall` is high.

## Interface
Parameters:
- `addr_width`, `` `A_BITS ``: SRAM address width
- `data_width`, `` `D_BITS ``: SRAM data width
- `max_burst`, 4: max consecutive locked host grants while core waits (≥1)

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rstn` in 1: asynchronous, active-low reset
- `c_req` in 1: core access request, held until granted
- `c_we` in 1: core write (1) / read (0)
- `c_addr` in `addr_width`: core address
- `c_wdata` in `data_width`: core write data
- `c_gnt` out 1: core access issued this cycle
- `c_stall` out 1: `c_req & ~c_gnt`
- `c_rvalid` out 1: read data valid for core
- `h_req`, `h_we`, `h_addr`, `h_wdata`: host equivalents of the core inputs
- `h_lock` in 1: host requests burst ownership
- `h_gnt`, `h_rvalid` out 1: host equivalents of the core outputs
- `rdata` out `data_width`: `mem_rdata` broadcast; qualify with `*_rvalid`
- `mem_en`, `mem_we` out 1; `mem_addr` out `addr_width`; `mem_wdata` out `data_width`: to `sram`
- `mem_rdata` in `data_width`: from `sram`, 1-cycle read latency

## Operation
- Grants are combinational from current inputs and registered state. At most one of `c_gnt`/`h_gnt` is high per cycle.
- `mem_en = c_gnt | h_gnt`. `mem_we`, `mem_addr` and `mem_wdata` are muxed from the granted port. With no grant, `mem_we=0` and the other mem outputs are 0.
- FSM (state reflects the last grant):
  - `ARB_C`: core granted last. On contention, host wins.
  - `ARB_H`: host granted last without lock. On contention, core wins.
  - `HLOCK`: host owns the bus.
    - Host is granted whenever `h_req`. Core is granted only if `!h_req`.
    - If `bcnt == max_burst` and `c_req`, core wins regardless.
- Transitions, evaluated on each grant:
  - Core grant → `ARB_C`, `bcnt=0`.
  - Host grant with `h_lock=1` → `HLOCK`, `bcnt+=1`, saturating at `max_burst`.
  - Host grant with `h_lock=0` → `ARB_H`, `bcnt=0`.
  - No grant → state and `bcnt` hold.
- While in `HLOCK` with `h_lock=0` and no host grant, the next host grant exits as above.
- `bcnt` width is `clog2(max_burst+1)` and never wraps.
- Read tracking: registered flags `rd_c <= c_gnt & ~c_we` and `rd_h <= h_gnt & ~h_we`. `c_rvalid=rd_c`, `h_rvalid=rd_h`.
- Back-to-back grants to either port, with no idle cycle, are legal.
- Writes produce no rvalid.

## Timing
- Reset (asynchronous, `rstn=0`): state `ARB_H` (core wins first contention), `bcnt=0`, `rd_c=rd_h=0`.
  - All outputs 0 while inputs are 0.
  - Grants remain combinational during reset only if `rstn=1`. While `rstn=0`, force both grants, `mem_en` and `mem_we` to 0.
- Reset mid-read: the pending rvalid is dropped and never asserted.
- Grant latency: 0 cycles when uncontested. Read data: `*_rvalid` and `rdata` one cycle after grant.
- A contested requester waits:
  - at most 1 cycle outside `HLOCK`;
  - core waits at most `max_burst` cycles in `HLOCK`.
- Simultaneous `c_req` and `h_req` with identical address, one writing: serialised by the FSM. Ordering is the grant order.
- Requests may change only after grant. Dropping `req` before grant is allowed and simply withdraws the request.

## Structure
- FSM state encodings (`ARB_C`, `ARB_H`, `HLOCK`, 2 bits) and the `max_burst` default go in `defs.vh` alongside `A_BITS`/`D_BITS`.
- One sub-module: `sram_rd_track`, the 2-flag registered read-return tracker with async reset. Instantiated once.
- Core integration: `c_stall` gates the PC update. `rdata` replaces `dataRam` into the result mux.

## Test plan
- Reset, then `c_req=1`, `c_we=0`, `c_addr=0x05`, with SRAM[5]=0xA3. Expect `c_gnt=1` same cycle, then `c_rvalid=1` and `rdata=0xA3` next cycle; `h_rvalid=0`.
- After reset, `c_req` and `h_req` rise together. Expect core granted cycle 0, host cycle 1, `c_stall=0` at cycle 1 (core dropped req), and state `ARB_H` after cycle 1.
- Continuous contention, both ports reading, no lock, 6 cycles. Expect grants alternating H,C,H,C… starting with the host (prior state `ARB_C`).
- `max_burst=4`, `h_lock=1`, host and core requesting continuously from state `HLOCK` entry. Expect 4 host grants, then 1 core grant, then host resumes. `c_stall=1` for exactly 4 cycles.
- Host write 0x3C to 0x10, then core read 0x10 in the next cycle. Expect `rdata=0x3C` with `c_rvalid` two cycles after the host grant.
- Core read granted, `rstn` pulsed low before the next edge. Expect `c_rvalid` never asserted, state `ARB_H`, `bcnt=0`.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the core/host SRAM arbiter.
package sram_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_C = 2'd0,
      ARB_H = 2'd1,
      HLOCK = 2'd2
   } arb_state_e;

   localparam int A_BITS        = 8;
   localparam int D_BITS        = 8;
   localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/sram_arbiter_if.sv
// Core, host and SRAM-side signals of the arbiter, grouped as one bus.
interface sram_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          c_req;
   logic          c_we;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata;
   logic          c_gnt;
   logic          c_stall;
   logic          c_rvalid;

   logic          h_req;
   logic          h_we;
   logic          h_lock;
   logic [AW-1:0] h_addr;
   logic [DW-1:0] h_wdata;
   logic          h_gnt;
   logic          h_rvalid;

   logic [DW-1:0] rdata;

   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      input  h_req, h_we, h_lock, h_addr, h_wdata,
      input  mem_rdata,
      output c_gnt, c_stall, c_rvalid,
      output h_gnt, h_rvalid, rdata,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata,
      output h_req, h_we, h_lock, h_addr, h_wdata,
      output mem_rdata,
      input  c_gnt, c_stall, c_rvalid,
      input  h_gnt, h_rvalid, rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/sram_arbiter_rd_track.sv
// Registered read-return flags: one cycle after a read grant, rvalid rises.
module sram_arbiter_rd_track (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic c_rd_i,
   input  logic h_rd_i,
   output logic c_rvalid_o,
   output logic h_rvalid_o
);

   logic rd_c_q;
   logic rd_h_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_c_q <= 1'b0;
         rd_h_q <= 1'b0;
      end else begin
         rd_c_q <= c_rd_i;
         rd_h_q <= h_rd_i;
      end
   end

   assign c_rvalid_o = rd_c_q;
   assign h_rvalid_o = rd_h_q;

endmodule

// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter: core load/store path vs host/DMA, with bounded host lock.
//
//   state | meaning
//   ARB_C | core granted last; host wins contention
//   ARB_H | host granted last (unlocked) or reset; core wins contention
//   HLOCK | host owns the bus; core wins only after max_burst locked grants
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = A_BITS,
   parameter int DATA_WIDTH = D_BITS,
   parameter int MAX_BURST  = MAX_BURST_DEF
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   sram_arbiter_if.slave  bus_if
);

   localparam int             BW       = $clog2(MAX_BURST + 1);
   localparam logic [BW-1:0]  BCNT_MAX = BW'(MAX_BURST);

   arb_state_e              state_q, state_d;
   logic [BW-1:0]           bcnt_q, bcnt_d;
   logic                    c_gnt;
   logic                    h_gnt;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH-1:0]   mem_wdata;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ARB_H;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         bcnt_q  <= bcnt_d;
      end
   end

   // Grants are forced low while reset is asserted, not just held by state.
   always_comb begin
      c_gnt = 1'b0;
      h_gnt = 1'b0;
      if (rst_n_i) begin
         case (state_q)
            ARB_C: begin
               h_gnt = bus_if.h_req;
               c_gnt = bus_if.c_req & ~bus_if.h_req;
            end
            HLOCK: begin
               if (bus_if.c_req && (bcnt_q == BCNT_MAX)) begin
                  c_gnt = 1'b1;
               end else begin
                  h_gnt = bus_if.h_req;
                  c_gnt = bus_if.c_req & ~bus_if.h_req;
               end
            end
            default: begin
               c_gnt = bus_if.c_req;
               h_gnt = bus_if.h_req & ~bus_if.c_req;
            end
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      if (c_gnt) begin
         state_d = ARB_C;
         bcnt_d  = '0;
      end else if (h_gnt) begin
         if (bus_if.h_lock) begin
            state_d = HLOCK;
            if (bcnt_q != BCNT_MAX) bcnt_d = bcnt_q + 1'b1;
         end else begin
            state_d = ARB_H;
            bcnt_d  = '0;
         end
      end
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (c_gnt) begin
         mem_we    = bus_if.c_we;
         mem_addr  = bus_if.c_addr;
         mem_wdata = bus_if.c_wdata;
      end else if (h_gnt) begin
         mem_we    = bus_if.h_we;
         mem_addr  = bus_if.h_addr;
         mem_wdata = bus_if.h_wdata;
      end
   end

   assign bus_if.c_gnt     = c_gnt;
   assign bus_if.h_gnt     = h_gnt;
   assign bus_if.c_stall   = bus_if.c_req & ~c_gnt;
   assign bus_if.mem_en    = c_gnt | h_gnt;
   assign bus_if.mem_we    = mem_we;
   assign bus_if.mem_addr  = mem_addr;
   assign bus_if.mem_wdata = mem_wdata;
   assign bus_if.rdata     = bus_if.mem_rdata;

   sram_arbiter_rd_track u_rd_track (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .c_rd_i     (c_gnt & ~bus_if.c_we),
      .h_rd_i     (h_gnt & ~bus_if.h_we),
      .c_rvalid_o (bus_if.c_rvalid),
      .h_rvalid_o (bus_if.h_rvalid)
   );

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_sram_arbiter;
   import sram_arbiter_pkg::*;

   localparam int MB = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   sram_arbiter_if #(.AW(8), .DW(8)) bus_if ();

   sram_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_BURST(MB)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus_if  (bus_if)
   );

   // SRAM model: 1-cycle read latency, contents preloaded on first edge
   logic [7:0] sram_mem [256];
   logic       mem_ready = 1'b0;

   function automatic logic [7:0] init_val(input int a);
      return (a == 5) ? 8'hA3 : 8'(a * 29 + 7);
   endfunction

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) sram_mem[i] <= init_val(i);
         bus_if.mem_rdata <= 8'h00;
         mem_ready <= 1'b1;
      end else if (bus_if.mem_en) begin
         if (bus_if.mem_we) sram_mem[bus_if.mem_addr] <= bus_if.mem_wdata;
         else               bus_if.mem_rdata <= sram_mem[bus_if.mem_addr];
      end
   end

   // Reference model: the side that did not win last is preferred; a locked
   // host streak yields to a waiting core once it reaches MB grants.
   logic [7:0] ref_mem [256];
   bit         m_last_core, m_locked;
   int         m_streak;
   bit         m_rd_c, m_rd_h;
   logic [7:0] m_rd_data;

   task automatic model_reset();
      m_last_core = 1'b0; m_locked = 1'b0; m_streak = 0;
      m_rd_c = 1'b0; m_rd_h = 1'b0;
   endtask

   task automatic model_grant(input bit cr, input bit hr, output bit ec, output bit eh);
      bit core_wins;
      if (cr && hr) begin
         if (m_locked) core_wins = (m_streak >= MB);
         else          core_wins = !m_last_core;
         ec = core_wins; eh = !core_wins;
      end else begin
         ec = cr; eh = hr;
      end
   endtask

   task automatic model_commit(input bit ec, input bit eh);
      m_rd_c = ec && !bus_if.c_we;
      m_rd_h = eh && !bus_if.h_we;
      if (ec) begin
         if (bus_if.c_we) ref_mem[bus_if.c_addr] = bus_if.c_wdata;
         else             m_rd_data = ref_mem[bus_if.c_addr];
         m_last_core = 1'b1; m_locked = 1'b0; m_streak = 0;
      end else if (eh) begin
         if (bus_if.h_we) ref_mem[bus_if.h_addr] = bus_if.h_wdata;
         else             m_rd_data = ref_mem[bus_if.h_addr];
         m_last_core = 1'b0;
         m_locked    = bus_if.h_lock;
         m_streak    = bus_if.h_lock ? ((m_streak + 1 > MB) ? MB : m_streak + 1) : 0;
      end
   endtask

   task automatic drive(input bit cr, input bit cw, input logic [7:0] ca, input logic [7:0] cd,
                        input bit hr, input bit hw, input bit hl,
                        input logic [7:0] ha, input logic [7:0] hd);
      @(posedge clk); #1;
      bus_if.c_req = cr; bus_if.c_we = cw; bus_if.c_addr = ca; bus_if.c_wdata = cd;
      bus_if.h_req = hr; bus_if.h_we = hw; bus_if.h_lock = hl;
      bus_if.h_addr = ha; bus_if.h_wdata = hd;
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus_if.c_req = 0; bus_if.c_we = 0; bus_if.c_addr = 0; bus_if.c_wdata = 0;
      bus_if.h_req = 0; bus_if.h_we = 0; bus_if.h_lock = 0;
      bus_if.h_addr = 0; bus_if.h_wdata = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      clear_inputs();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if ({bus_if.c_gnt, bus_if.h_gnt, bus_if.c_stall, bus_if.c_rvalid, bus_if.h_rvalid} !== 5'b0) begin
         n_fail++; $display("FAIL reset_ctrl_outs got=%b exp=00000",
            {bus_if.c_gnt, bus_if.h_gnt, bus_if.c_stall, bus_if.c_rvalid, bus_if.h_rvalid}); end
      n_cmp++; if ({bus_if.mem_en, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata, bus_if.rdata} !== 26'b0) begin
         n_fail++; $display("FAIL reset_mem_outs got=%h exp=0",
            {bus_if.mem_en, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata, bus_if.rdata}); end
      bus_if.c_req = 1; bus_if.c_we = 1; bus_if.h_req = 1; bus_if.h_we = 1; bus_if.h_lock = 1;
      #1;
      n_cmp++; if ({bus_if.c_gnt, bus_if.h_gnt, bus_if.mem_en, bus_if.mem_we} !== 4'b0) begin
         n_fail++; $display("FAIL reset_forced_gnt got=%b exp=0000",
            {bus_if.c_gnt, bus_if.h_gnt, bus_if.mem_en, bus_if.mem_we}); end
      @(posedge clk); #1;
      clear_inputs();
      rst_n = 1'b1;
   endtask

   task automatic test_core_read();
      bit ec, eh;
      drive(1, 0, 8'h05, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      model_grant(1, 0, ec, eh);
      n_cmp++; if (bus_if.c_gnt !== 1'b1) begin n_fail++; $display("FAIL core_read_gnt got=%b exp=1", bus_if.c_gnt); end
      n_cmp++; if (bus_if.mem_addr !== 8'h05) begin n_fail++; $display("FAIL core_read_addr got=%h exp=05", bus_if.mem_addr); end
      model_commit(ec, eh);
      drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      n_cmp++; if (bus_if.c_rvalid !== 1'b1) begin n_fail++; $display("FAIL core_read_rvalid got=%b exp=1", bus_if.c_rvalid); end
      n_cmp++; if (bus_if.rdata !== 8'hA3) begin n_fail++; $display("FAIL core_read_rdata got=%h exp=a3", bus_if.rdata); end
      n_cmp++; if (bus_if.h_rvalid !== 1'b0) begin n_fail++; $display("FAIL core_read_hrvalid got=%b exp=0", bus_if.h_rvalid); end
      model_commit(0, 0);
   endtask

   task automatic test_simultaneous();
      bit ec, eh;
      do_reset();
      drive(1, 0, 8'h01, 8'h00, 1, 0, 0, 8'h02, 8'h00);
      model_grant(1, 1, ec, eh);
      n_cmp++; if ({bus_if.c_gnt, bus_if.h_gnt} !== 2'b10) begin n_fail++; $display("FAIL sim_cycle0 got=%b exp=10", {bus_if.c_gnt, bus_if.h_gnt}); end
      model_commit(ec, eh);
      drive(0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h02, 8'h00);
      n_cmp++; if ({bus_if.c_gnt, bus_if.h_gnt, bus_if.c_stall} !== 3'b010) begin
         n_fail++; $display("FAIL sim_cycle1 got=%b exp=010", {bus_if.c_gnt, bus_if.h_gnt, bus_if.c_stall}); end
      n_cmp++; if (bus_if.c_rvalid !== 1'b1 || bus_if.rdata !== ref_mem[1]) begin
         n_fail++; $display("FAIL sim_core_data got=%b/%h exp=1/%h", bus_if.c_rvalid, bus_if.rdata, ref_mem[1]); end
      model_commit(0, 1);
      drive(1, 0, 8'h03, 8'h00, 1, 0, 0, 8'h04, 8'h00);
      model_grant(1, 1, ec, eh);
      n_cmp++; if ({bus_if.c_gnt, bus_if.h_gnt} !== 2'b10) begin n_fail++; $display("FAIL sim_state_arb_h got=%b exp=10", {bus_if.c_gnt, bus_if.h_gnt}); end
      n_cmp++; if (bus_if.h_rvalid !== 1'b1 || bus_if.rdata !== ref_mem[2]) begin
         n_fail++; $display("FAIL sim_host_data got=%b/%h exp=1/%h", bus_if.h_rvalid, bus_if.rdata, ref_mem[2]); end
      model_commit(ec, eh);
   endtask

   task automatic test_alternate();
      bit ec, eh;
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 8'(8'h20 + i), 8'h00, 1, 0, 0, 8'(8'h40 + i), 8'h00);
         model_grant(1, 1, ec, eh);
         n_cmp++; if ({bus_if.c_gnt, bus_if.h_gnt} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
            n_fail++; $display("FAIL alt_grant[%0d] got=%b exp=%b", i, {bus_if.c_gnt, bus_if.h_gnt}, (i % 2 == 0) ? 2'b01 : 2'b10); end
         n_cmp++; if ({bus_if.c_rvalid, bus_if.h_rvalid} !== {m_rd_c, m_rd_h} ||
                      ((m_rd_c || m_rd_h) && bus_if.rdata !== m_rd_data)) begin
            n_fail++; $display("FAIL alt_rdata[%0d] got=%b%b/%h exp=%b%b/%h", i, bus_if.c_rvalid, bus_if.h_rvalid,
               bus_if.rdata, m_rd_c, m_rd_h, m_rd_data); end
         model_commit(ec, eh);
      end
   endtask

   task automatic test_burst();
      bit ec, eh;
      int stalls;
      stalls = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 8'(8'h60 + i), 8'h00, 1, 0, 1, 8'(8'h80 + i), 8'h00);
         model_grant(1, 1, ec, eh);
         n_cmp++; if ({bus_if.c_gnt, bus_if.h_gnt} !== ((i % 5 != 4) ? 2'b01 : 2'b10)) begin
            n_fail++; $display("FAIL burst_grant[%0d] got=%b exp=%b", i, {bus_if.c_gnt, bus_if.h_gnt}, (i % 5 != 4) ? 2'b01 : 2'b10); end
         if (i < 5 && bus_if.c_stall) stalls++;
         model_commit(ec, eh);
      end
      n_cmp++; if (stalls != MB) begin n_fail++; $display("FAIL burst_stall_cycles got=%0d exp=%0d", stalls, MB); end
   endtask

   task automatic test_raw();
      bit ec, eh;
      drive(0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h10, 8'h3C);
      model_grant(0, 1, ec, eh);
      n_cmp++; if ({bus_if.h_gnt, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata} !== {2'b11, 8'h10, 8'h3C}) begin
         n_fail++; $display("FAIL raw_host_write got=%b%b/%h/%h exp=11/10/3c", bus_if.h_gnt, bus_if.mem_we,
            bus_if.mem_addr, bus_if.mem_wdata); end
      model_commit(ec, eh);
      drive(1, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      n_cmp++; if ({bus_if.c_rvalid, bus_if.h_rvalid} !== 2'b00) begin
         n_fail++; $display("FAIL raw_write_no_rvalid got=%b exp=00", {bus_if.c_rvalid, bus_if.h_rvalid}); end
      model_commit(1, 0);
      drive(0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      n_cmp++; if (bus_if.c_rvalid !== 1'b1 || bus_if.rdata !== 8'h3C) begin
         n_fail++; $display("FAIL raw_core_read got=%b/%h exp=1/3c", bus_if.c_rvalid, bus_if.rdata); end
      model_commit(0, 0);
   endtask

   task automatic test_reset_mid_read();
      bit ec, eh;
      drive(1, 0, 8'h05, 8'h00, 0, 0, 0, 8'h00, 8'h00);
      n_cmp++; if (bus_if.c_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_gnt got=%b exp=1", bus_if.c_gnt); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({bus_if.c_gnt, bus_if.mem_en} !== 2'b00) begin
         n_fail++; $display("FAIL midrst_forced got=%b exp=00", {bus_if.c_gnt, bus_if.mem_en}); end
      model_reset();
      @(posedge clk); #1;
      clear_inputs();
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if ({bus_if.c_rvalid, bus_if.h_rvalid} !== 2'b00) begin
         n_fail++; $display("FAIL midrst_rvalid0 got=%b exp=00", {bus_if.c_rvalid, bus_if.h_rvalid}); end
      drive(1, 0, 8'h06, 8'h00, 1, 0, 1, 8'h07, 8'h00);
      model_grant(1, 1, ec, eh);
      n_cmp++; if (bus_if.c_rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_rvalid1 got=%b exp=0", bus_if.c_rvalid); end
      n_cmp++; if ({bus_if.c_gnt, bus_if.h_gnt} !== 2'b10) begin
         n_fail++; $display("FAIL midrst_state got=%b exp=10", {bus_if.c_gnt, bus_if.h_gnt}); end
      model_commit(ec, eh);
   endtask

   task automatic test_random();
      bit ec, eh, cp, hp, cw, hw, hl;
      logic [7:0] ca, cd, ha, hd;
      int run;
      logic [7:0] e_addr, e_wdata;
      bit e_we;
      cp = 0; hp = 0; run = 0;
      cw = 0; hw = 0; hl = 0; ca = 0; cd = 0; ha = 0; hd = 0;
      for (int i = 0; i < 400; i++) begin
         if (cp && $urandom_range(0, 19) == 0) cp = 0;
         if (!cp && $urandom_range(0, 9) < 7) begin
            cp = 1; cw = ($urandom_range(0, 2) == 0); ca = 8'($urandom_range(0, 15)); cd = 8'($urandom);
         end
         if (!hp && $urandom_range(0, 9) < 7) begin
            hp = 1; hw = ($urandom_range(0, 2) == 0); hl = ($urandom_range(0, 3) != 0);
            ha = 8'($urandom_range(0, 15)); hd = 8'($urandom);
         end
         drive(cp, cw, ca, cd, hp, hw, hl, ha, hd);
         model_grant(cp, hp, ec, eh);
         e_we    = ec ? cw : (eh ? hw : 1'b0);
         e_addr  = ec ? ca : (eh ? ha : 8'h00);
         e_wdata = ec ? cd : (eh ? hd : 8'h00);
         n_cmp++; if ({bus_if.c_gnt, bus_if.h_gnt, bus_if.c_stall, bus_if.mem_en} !== {ec, eh, cp & ~ec, ec | eh}) begin
            n_fail++; $display("FAIL rnd_grant[%0d] got=%b exp=%b", i,
               {bus_if.c_gnt, bus_if.h_gnt, bus_if.c_stall, bus_if.mem_en}, {ec, eh, cp & ~ec, ec | eh}); end
         n_cmp++; if ({bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata} !== {e_we, e_addr, e_wdata}) begin
            n_fail++; $display("FAIL rnd_mem[%0d] got=%b/%h/%h exp=%b/%h/%h", i, bus_if.mem_we,
               bus_if.mem_addr, bus_if.mem_wdata, e_we, e_addr, e_wdata); end
         n_cmp++; if ({bus_if.c_rvalid, bus_if.h_rvalid} !== {m_rd_c, m_rd_h} ||
                      ((m_rd_c || m_rd_h) && bus_if.rdata !== m_rd_data)) begin
            n_fail++; $display("FAIL rnd_rdata[%0d] got=%b%b/%h exp=%b%b/%h", i, bus_if.c_rvalid, bus_if.h_rvalid,
               bus_if.rdata, m_rd_c, m_rd_h, m_rd_data); end
         run = bus_if.c_stall ? run + 1 : 0;
         n_cmp++; if (run > MB) begin n_fail++; $display("FAIL rnd_core_wait[%0d] got=%0d exp<=%0d", i, run, MB); end
         model_commit(ec, eh);
         if (ec) cp = 0;
         if (eh) hp = 0;
      end
   endtask

   initial begin
      test_reset();
      test_core_read();
      test_simultaneous();
      test_alternate();
      test_burst();
      test_raw();
      test_reset_mid_read();
      test_random();
      @(posedge clk); #1;
      clear_inputs();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
